// File: rtl/rx_pixel_decryptor.sv
// rx_pixel_decryptor: buffers chaotic-LFSR key triples and XORs one key into each encrypted pixel.
// Latency: 1 cycle from pixel accept to dec_valid; a captured key is usable the cycle after key_ready.
// Backpressure: enc_ready low while no key is buffered or the output register is held; keys cannot be stalled, so a drop sets key_overflow.
//
// Ports:
//   clk, rst            single clock, asynchronous active-low reset
//   key_r/g/b,key_ready generator key bytes and their one-cycle strobe
//   enc_r/g/b,enc_valid encrypted pixel in, accepted on enc_valid && enc_ready
//   dec_r/g/b,dec_valid decrypted pixel out (registered), taken on dec_valid && dec_ready
//   key_level           key FIFO occupancy
//   key_overflow        sticky: a key arrived while the FIFO was full and not being read
//   pix_count           pixels taken downstream, wraps at 16 bits
module rx_pixel_decryptor #(
  parameter int KEY_DEPTH = 4,
  parameter int PIX_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PIX_W-1:0]             key_r,
  input  logic [PIX_W-1:0]             key_g,
  input  logic [PIX_W-1:0]             key_b,
  input  logic                         key_ready,
  input  logic [PIX_W-1:0]             enc_r,
  input  logic [PIX_W-1:0]             enc_g,
  input  logic [PIX_W-1:0]             enc_b,
  input  logic                         enc_valid,
  output logic                         enc_ready,
  output logic [PIX_W-1:0]             dec_r,
  output logic [PIX_W-1:0]             dec_g,
  output logic [PIX_W-1:0]             dec_b,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic [$clog2(KEY_DEPTH):0]   key_level,
  output logic                         key_overflow,
  output logic [15:0]                  pix_count
);

  localparam int AW = $clog2(KEY_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(KEY_DEPTH);

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pix_t;

  pix_t        key_mem [KEY_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  pix_t        head_key;
  pix_t        wr_key;
  logic        key_full;
  logic        key_empty;
  logic        out_free;
  logic        accept;
  logic        key_wr;
  logic        key_drop;
  logic        dec_take;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign key_level = wptr - rptr;
  assign key_full  = (key_level == FULL_LEVEL);
  assign key_empty = (key_level == '0);

  // The output register can take a new pixel when it is empty or being drained.
  assign out_free  = !dec_valid || dec_ready;
  assign enc_ready = !key_empty && out_free;
  assign accept    = enc_valid && enc_ready;
  assign dec_take  = dec_valid && dec_ready;

  // A read in the same cycle frees the slot, so a full FIFO still takes the key.
  assign key_wr    = key_ready && (!key_full || accept);
  assign key_drop  = key_ready && key_full && !accept;

  assign head_key  = key_mem[rptr[AW-1:0]];
  assign wr_key    = {key_r, key_g, key_b};

  // Key storage needs no reset: entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (key_wr) begin
      key_mem[wptr[AW-1:0]] <= wr_key;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr         <= '0;
      rptr         <= '0;
      key_overflow <= 1'b0;
      dec_r        <= '0;
      dec_g        <= '0;
      dec_b        <= '0;
      dec_valid    <= 1'b0;
      pix_count    <= '0;
    end else begin
      if (key_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (key_drop) begin
        key_overflow <= 1'b1;
      end
      if (accept) begin
        rptr      <= rptr + 1'b1;
        dec_r     <= enc_r ^ head_key.r;
        dec_g     <= enc_g ^ head_key.g;
        dec_b     <= enc_b ^ head_key.b;
        dec_valid <= 1'b1;
      end else if (dec_take) begin
        // Drained with nothing behind it: data holds its last value.
        dec_valid <= 1'b0;
      end
      if (dec_take) begin
        pix_count <= pix_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rx_pixel_decryptor.sv
module tb_rx_pixel_decryptor;

  localparam int KD = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] key_r = '0, key_g = '0, key_b = '0;
  logic          key_ready = 1'b0;
  logic [PW-1:0] enc_r = '0, enc_g = '0, enc_b = '0;
  logic          enc_valid = 1'b0;
  logic          enc_ready;
  logic [PW-1:0] dec_r, dec_g, dec_b;
  logic          dec_valid;
  logic          dec_ready = 1'b0;
  logic [2:0]    key_level;
  logic          key_overflow;
  logic [15:0]   pix_count;

  always #5 clk = ~clk;

  rx_pixel_decryptor #(.KEY_DEPTH(KD), .PIX_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_r        (key_r),
    .key_g        (key_g),
    .key_b        (key_b),
    .key_ready    (key_ready),
    .enc_r        (enc_r),
    .enc_g        (enc_g),
    .enc_b        (enc_b),
    .enc_valid    (enc_valid),
    .enc_ready    (enc_ready),
    .dec_r        (dec_r),
    .dec_g        (dec_g),
    .dec_b        (dec_b),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .key_level    (key_level),
    .key_overflow (key_overflow),
    .pix_count    (pix_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Bench model: key queue, expected-output scoreboard, output-valid, overflow and count.
  logic [23:0] m_keys[$];
  logic [23:0] exp_q[$];
  logic        m_dv  = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_cnt = 16'd0;
  logic        last_acc = 1'b0;

  // Advance one clock and update the model from the inputs held across that edge.
  task automatic tick();
    logic        acc, drain;
    logic [23:0] pix, k;
    acc   = enc_valid && rst && (m_keys.size() != 0) && (!m_dv || dec_ready);
    drain = m_dv && dec_ready;
    pix   = {enc_r, enc_g, enc_b};
    @(posedge clk); #1;
    if (drain) m_cnt = m_cnt + 16'd1;
    if (acc) begin
      k = m_keys.pop_front();
      exp_q.push_back(pix ^ k);
      m_dv = 1'b1;
    end else if (drain) begin
      m_dv = 1'b0;
    end
    if (key_ready) begin
      if (m_keys.size() < KD) m_keys.push_back({key_r, key_g, key_b});
      else m_ovf = 1'b1;
    end
    last_acc = acc;
  endtask

  task automatic idle_inputs();
    key_ready = 1'b0;
    enc_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle_inputs();
    m_keys.delete();
    exp_q.delete();
    m_dv = 1'b0; m_ovf = 1'b0; m_cnt = 16'd0; last_acc = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
  endtask

  task automatic drain_output();
    for (int c = 0; c < 4 && m_dv; c++) tick();
  endtask

  // Scoreboard and cycle-by-cycle model check, sampled away from the active edge.
  always @(negedge clk) begin : monitor
    logic [23:0] want;
    logic        rdy_exp;
    rdy_exp = rst && (m_keys.size() != 0) && (!m_dv || dec_ready);
    n_cmp++;
    if (enc_ready !== rdy_exp) begin
      n_err++; $display("FAIL mon_enc_ready: got %b want %b at %0t", enc_ready, rdy_exp, $time);
    end
    n_cmp++;
    if (dec_valid !== m_dv) begin
      n_err++; $display("FAIL mon_dec_valid: got %b want %b at %0t", dec_valid, m_dv, $time);
    end
    n_cmp++;
    if (key_level !== 3'(m_keys.size())) begin
      n_err++; $display("FAIL mon_key_level: got %0d want %0d at %0t", key_level, m_keys.size(), $time);
    end
    n_cmp++;
    if (key_overflow !== m_ovf) begin
      n_err++; $display("FAIL mon_overflow: got %b want %b at %0t", key_overflow, m_ovf, $time);
    end
    n_cmp++;
    if (pix_count !== m_cnt) begin
      n_err++; $display("FAIL mon_pix_count: got %h want %h at %0t", pix_count, m_cnt, $time);
    end
    if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL sb_unexpected: got %h want nothing at %0t", {dec_r, dec_g, dec_b}, $time);
      end else begin
        want = exp_q.pop_front();
        if ({dec_r, dec_g, dec_b} !== want) begin
          n_err++; $display("FAIL sb_pixel: got %h want %h at %0t", {dec_r, dec_g, dec_b}, want, $time);
        end
      end
    end
  end

  task automatic test_reset();
    enc_valid = 1'b1; key_ready = 1'b1; dec_ready = 1'b1;
    key_r = 8'h11; key_g = 8'h22; key_b = 8'h33;
    enc_r = 8'h44; enc_g = 8'h55; enc_b = 8'h66;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if ({enc_ready, dec_valid, key_overflow} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {enc_ready, dec_valid, key_overflow});
    end
    n_cmp++;
    if (key_level !== 3'd0) begin
      n_err++; $display("FAIL reset_level: got %0d want 0", key_level);
    end
    n_cmp++;
    if ({dec_r, dec_g, dec_b, pix_count} !== 40'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {dec_r, dec_g, dec_b, pix_count});
    end
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_single();
    dec_ready = 1'b1;
    key_r = 8'h5A; key_g = 8'hC3; key_b = 8'h0F; key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    n_cmp++;
    if (key_level !== 3'd1) begin
      n_err++; $display("FAIL single_level_after_key: got %0d want 1", key_level);
    end
    enc_r = 8'hFF; enc_g = 8'h00; enc_b = 8'hF0; enc_valid = 1'b1;
    tick();
    enc_valid = 1'b0;
    n_cmp++;
    if ({dec_valid, dec_r, dec_g, dec_b} !== {1'b1, 24'hA5C3FF}) begin
      n_err++; $display("FAIL single_pixel: got %b/%h want 1/a5c3ff", dec_valid, {dec_r, dec_g, dec_b});
    end
    n_cmp++;
    if (key_level !== 3'd0) begin
      n_err++; $display("FAIL single_level_after_pop: got %0d want 0", key_level);
    end
    tick();
    n_cmp++;
    if (pix_count !== 16'd1) begin
      n_err++; $display("FAIL single_count: got %0d want 1", pix_count);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] keys [3];
    logic [23:0] pixs [3];
    int idx;
    keys[0] = 24'h123456; keys[1] = 24'hABCDEF; keys[2] = 24'h0F1E2D;
    pixs[0] = 24'h808080; pixs[1] = 24'h7F00FF; pixs[2] = 24'h55AA33;
    reset_dut();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {key_r, key_g, key_b} = keys[i]; key_ready = 1'b1;
      tick();
    end
    key_ready = 1'b0;
    {enc_r, enc_g, enc_b} = pixs[0]; enc_valid = 1'b1;
    tick();
    {enc_r, enc_g, enc_b} = pixs[1];
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({dec_r, dec_g, dec_b} !== (pixs[0] ^ keys[0])) begin
        n_err++; $display("FAIL bp_hold_data: got %h want %h", {dec_r, dec_g, dec_b}, pixs[0] ^ keys[0]);
      end
      n_cmp++;
      if ({enc_ready, key_level} !== {1'b0, 3'd2}) begin
        n_err++; $display("FAIL bp_hold_ready_level: got %b/%0d want 0/2", enc_ready, key_level);
      end
    end
    dec_ready = 1'b1;
    idx = 1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      tick();
      if (last_acc) begin
        idx++;
        if (idx < 3) {enc_r, enc_g, enc_b} = pixs[idx];
        else enc_valid = 1'b0;
      end
    end
    enc_valid = 1'b0;
    n_cmp++;
    if (idx != 3) begin
      n_err++; $display("FAIL bp_stream_timeout: got %0d accepted want 3", idx);
    end
    drain_output();
    n_cmp++;
    if ({dec_r, dec_g, dec_b} !== (pixs[2] ^ keys[2])) begin
      n_err++; $display("FAIL bp_last_pixel: got %h want %h", {dec_r, dec_g, dec_b}, pixs[2] ^ keys[2]);
    end
    n_cmp++;
    if (pix_count !== 16'd3) begin
      n_err++; $display("FAIL bp_count: got %0d want 3", pix_count);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] keys [5];
    int acc;
    for (int i = 0; i < 5; i++) keys[i] = 24'h101010 * (i + 1);
    reset_dut();
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {key_r, key_g, key_b} = keys[i]; key_ready = 1'b1;
      tick();
    end
    key_ready = 1'b0;
    n_cmp++;
    if ({key_level, key_overflow} !== {3'd4, 1'b1}) begin
      n_err++; $display("FAIL ovf_full: got %0d/%b want 4/1", key_level, key_overflow);
    end
    {enc_r, enc_g, enc_b} = 24'h000000; enc_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      tick();
      if (last_acc) acc++;
    end
    enc_valid = 1'b0;
    drain_output();
    n_cmp++;
    if ({dec_r, dec_g, dec_b} !== keys[3]) begin
      n_err++; $display("FAIL ovf_last_key: got %h want %h", {dec_r, dec_g, dec_b}, keys[3]);
    end
    n_cmp++;
    if ({key_level, key_overflow, enc_ready} !== {3'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL ovf_fifth_absent: got %0d/%b/%b want 0/1/0", key_level, key_overflow, enc_ready);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [23:0] k5, p4;
    int acc;
    reset_dut();
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {key_r, key_g, key_b} = 24'hA00000 + 24'(i); key_ready = 1'b1;
      tick();
    end
    k5 = 24'h3C6E91;
    p4 = 24'hDEAD01;
    {key_r, key_g, key_b} = k5; key_ready = 1'b1;
    {enc_r, enc_g, enc_b} = 24'h010203; enc_valid = 1'b1;
    tick();
    key_ready = 1'b0;
    n_cmp++;
    if ({key_level, key_overflow} !== {3'd4, 1'b0}) begin
      n_err++; $display("FAIL full_simul_level: got %0d/%b want 4/0", key_level, key_overflow);
    end
    acc = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      {enc_r, enc_g, enc_b} = (acc == 3) ? p4 : 24'h111111 * (acc + 1);
      tick();
      if (last_acc) acc++;
    end
    enc_valid = 1'b0;
    drain_output();
    n_cmp++;
    if ({dec_r, dec_g, dec_b} !== (p4 ^ k5)) begin
      n_err++; $display("FAIL full_simul_new_key: got %h want %h", {dec_r, dec_g, dec_b}, p4 ^ k5);
    end
  endtask

  // Keys arrive every cycle here so the 16-bit wrap is reached quickly at full throughput.
  task automatic test_back_to_back_wrap();
    int  acc;
    bit  seen_ffff;
    reset_dut();
    dec_ready = 1'b1;
    {key_r, key_g, key_b} = 24'($urandom); key_ready = 1'b1;
    {enc_r, enc_g, enc_b} = 24'($urandom); enc_valid = 1'b1;
    acc = 0;
    seen_ffff = 1'b0;
    for (int c = 0; c < 70000 && acc < 65536; c++) begin
      tick();
      if (last_acc) begin
        acc++;
        {enc_r, enc_g, enc_b} = 24'($urandom);
      end
      {key_r, key_g, key_b} = 24'($urandom);
      if (acc == 65536) idle_inputs();
      if (m_cnt == 16'hFFFF && !seen_ffff) begin
        seen_ffff = 1'b1;
        n_cmp++;
        if (pix_count !== 16'hFFFF) begin
          n_err++; $display("FAIL wrap_pre: got %h want ffff", pix_count);
        end
      end
    end
    idle_inputs();
    n_cmp++;
    if (acc != 65536) begin
      n_err++; $display("FAIL wrap_timeout: got %0d accepted want 65536", acc);
    end
    drain_output();
    n_cmp++;
    if ({pix_count, key_overflow} !== {16'h0000, 1'b0}) begin
      n_err++; $display("FAIL wrap_count: got %h/%b want 0000/0", pix_count, key_overflow);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL wrap_outstanding: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_simultaneous();
    test_back_to_back_wrap();
    repeat (2) begin @(posedge clk); #1; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
